// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase sequencer.
package traffic_pkg;

  // Width of the phase down-counter; every duration fits in 1..255 ticks.
  localparam int TMR_W = 8;

  // Sequencer phases, 3-bit encoded.
  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_ALLRED_A  = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_ALLRED_B  = 3'd5,
    ST_WALK      = 3'd6,
    ST_FLASH     = 3'd7
  } phase_t;

  // Lamp drive patterns, {R,Y,G}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// Phase duration down-counter: loaded with (duration-1) on phase entry,
// counts 1 Hz ticks, and flags the terminal tick of the phase.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [TMR_W-1:0] RST_VAL = '0
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [TMR_W-1:0] count_reg;

  // Load takes priority; otherwise decrement on tick and park at zero.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      count_reg <= RST_VAL;
    end else if (load) begin
      count_reg <= load_val;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  // The phase ends on the tick that finds the counter already at zero.
  assign done = tick && (count_reg == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer with pedestrian service and night flash.
// Lamp outputs are Moore, registered from the current phase.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN_NS = 10,
  parameter int T_GREEN_EW = 6,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 1,
  parameter int T_WALK     = 8
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       tick,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       flash,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending
);

  localparam logic [TMR_W-1:0] LD_GREEN_NS = TMR_W'(T_GREEN_NS - 1);
  localparam logic [TMR_W-1:0] LD_GREEN_EW = TMR_W'(T_GREEN_EW - 1);
  localparam logic [TMR_W-1:0] LD_YELLOW   = TMR_W'(T_YELLOW - 1);
  localparam logic [TMR_W-1:0] LD_ALLRED   = TMR_W'(T_ALLRED - 1);
  localparam logic [TMR_W-1:0] LD_WALK     = TMR_W'(T_WALK - 1);

  phase_t           state_reg, state_next;
  logic             timer_load, timer_done;
  logic [TMR_W-1:0] timer_val;
  logic             ped_reg, ped_next;
  logic             flash_on_reg, flash_on_next;
  logic [2:0]       ns_reg, ns_next, ew_reg, ew_next;
  logic             walk_reg, walk_next;

  phase_timer #(
    .RST_VAL (LD_ALLRED)
  ) u_timer (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .load       (timer_load),
    .load_val   (timer_val),
    .tick       (tick),
    .done       (timer_done)
  );

  // Next phase and timer reload on every phase change.
  always_comb begin
    state_next = state_reg;
    timer_val  = '0;
    case (state_reg)
      ST_NS_GREEN:  if (timer_done && (ew_car || ped_reg)) state_next = ST_NS_YELLOW;
      ST_NS_YELLOW: if (timer_done) state_next = ST_ALLRED_A;
      ST_ALLRED_A:  if (timer_done) state_next = flash ? ST_FLASH : ST_EW_GREEN;
      ST_EW_GREEN:  if (timer_done) state_next = ST_EW_YELLOW;
      ST_EW_YELLOW: if (timer_done) state_next = ST_ALLRED_B;
      ST_ALLRED_B: begin
        if (timer_done) begin
          if (flash)        state_next = ST_FLASH;
          else if (ped_reg) state_next = ST_WALK;
          else              state_next = ST_NS_GREEN;
        end
      end
      ST_WALK:      if (timer_done) state_next = ST_NS_GREEN;
      ST_FLASH:     if (tick && !flash) state_next = ST_ALLRED_B;
      default:      state_next = ST_ALLRED_B;
    endcase
    timer_load = (state_next != state_reg);
    case (state_next)
      ST_NS_GREEN:  timer_val = LD_GREEN_NS;
      ST_NS_YELLOW: timer_val = LD_YELLOW;
      ST_ALLRED_A:  timer_val = LD_ALLRED;
      ST_EW_GREEN:  timer_val = LD_GREEN_EW;
      ST_EW_YELLOW: timer_val = LD_YELLOW;
      ST_ALLRED_B:  timer_val = LD_ALLRED;
      ST_WALK:      timer_val = LD_WALK;
      default:      timer_val = '0;
    endcase
  end

  // Lamp decode of the current phase, pedestrian latch and flash blink phase.
  always_comb begin
    ns_next   = LAMP_R;
    ew_next   = LAMP_R;
    walk_next = 1'b0;
    case (state_reg)
      ST_NS_GREEN:  ns_next = LAMP_G;
      ST_NS_YELLOW: ns_next = LAMP_Y;
      ST_EW_GREEN:  ew_next = LAMP_G;
      ST_EW_YELLOW: ew_next = LAMP_Y;
      ST_WALK:      walk_next = 1'b1;
      ST_FLASH: begin
        ns_next = flash_on_reg ? LAMP_Y : LAMP_OFF;
        ew_next = flash_on_reg ? LAMP_R : LAMP_OFF;
      end
      default: begin
        ns_next = LAMP_R;
        ew_next = LAMP_R;
      end
    endcase
    // Entering WALK serves the request, even if the button is still pressed.
    if ((state_next == ST_WALK) && (state_reg != ST_WALK)) ped_next = 1'b0;
    else                                                   ped_next = ped_reg | ped_req;
    // Flash starts lit, then toggles on every tick while flashing.
    flash_on_next = flash_on_reg;
    if ((state_next == ST_FLASH) && (state_reg != ST_FLASH)) flash_on_next = 1'b1;
    else if ((state_reg == ST_FLASH) && tick)                flash_on_next = ~flash_on_reg;
  end

  // Phase, latch and lamp registers; reset parks in all-red clearance.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_ALLRED_B;
      ped_reg      <= 1'b0;
      flash_on_reg <= 1'b0;
      ns_reg       <= LAMP_R;
      ew_reg       <= LAMP_R;
      walk_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ped_reg      <= ped_next;
      flash_on_reg <= flash_on_next;
      ns_reg       <= ns_next;
      ew_reg       <= ew_next;
      walk_reg     <= walk_next;
    end
  end

  assign ns_light    = ns_reg;
  assign ew_light    = ew_reg;
  assign walk        = walk_reg;
  assign ped_pending = ped_reg;

endmodule
